// File: rtl/mdu.sv
// mdu: multi-cycle multiply/divide unit owning the architectural HI/LO pair.
// Define MDU_MADD_EN to add the MADD/MADDU/MSUB/MSUBU accumulate operations.
//
//   state  | meaning
//   IDLE   | accepts Start; MTHI/MTLO write directly, arithmetic ops launch
//   RUN    | result pending in PHI/PLO, counting down to commit; Busy high
module mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] SrcA,
  input  logic [31:0] SrcB,
  input  logic [3:0]  MDUOp,
  input  logic        Start,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef MDU_MADD_EN
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MADDU = 4'd8;
  localparam logic [3:0] OP_MSUB  = 4'd9;
  localparam logic [3:0] OP_MSUBU = 4'd10;
`endif

  localparam logic [4:0] LP_MULT_CNT = 5'(MULT_CYCLES);
  localparam logic [4:0] LP_DIV_CNT  = 5'(DIV_CYCLES);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        w_done;
  logic [4:0]  r_cnt;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic [31:0] r_phi;
  logic [31:0] r_plo;
  logic        r_pwr;

  logic        w_op_mul;
  logic        w_op_div;
  logic        w_op_acc;
  logic        w_idle_start;
  logic        w_launch;
  logic        w_div_zero;

  logic [63:0] w_a_sx;
  logic [63:0] w_b_sx;
  logic [63:0] w_a_zx;
  logic [63:0] w_b_zx;
  logic [63:0] w_prod_s;
  logic [63:0] w_prod_u;

  logic        w_a_neg;
  logic        w_b_neg;
  logic [31:0] w_a_mag;
  logic [31:0] w_b_mag;
  logic [31:0] w_q_mag;
  logic [31:0] w_r_mag;
  logic [31:0] w_quo;
  logic [31:0] w_rem;

  logic [63:0] w_result;

  assign w_op_mul     = (MDUOp == OP_MULT) || (MDUOp == OP_MULTU);
  assign w_op_div     = (MDUOp == OP_DIV)  || (MDUOp == OP_DIVU);
`ifdef MDU_MADD_EN
  assign w_op_acc     = (MDUOp == OP_MADD) || (MDUOp == OP_MADDU) ||
                        (MDUOp == OP_MSUB) || (MDUOp == OP_MSUBU);
`else
  assign w_op_acc     = 1'b0;
`endif
  assign w_idle_start = Start && (r_state == S_IDLE);
  assign w_launch     = w_idle_start && (w_op_mul || w_op_div || w_op_acc);
  assign w_div_zero   = w_op_div && (SrcB == 32'd0);

  // Low 64 bits of a 64x64 product equal the exact 32x32 product.
  assign w_a_sx   = {{32{SrcA[31]}}, SrcA};
  assign w_b_sx   = {{32{SrcB[31]}}, SrcB};
  assign w_a_zx   = {32'd0, SrcA};
  assign w_b_zx   = {32'd0, SrcB};
  assign w_prod_s = w_a_sx * w_b_sx;
  assign w_prod_u = w_a_zx * w_b_zx;

  // Signed divide via magnitudes so 0x80000000 / -1 wraps without overflow traps.
  assign w_a_neg = (MDUOp == OP_DIV) && SrcA[31];
  assign w_b_neg = (MDUOp == OP_DIV) && SrcB[31];
  assign w_a_mag = w_a_neg ? (32'd0 - SrcA) : SrcA;
  assign w_b_mag = (SrcB == 32'd0) ? 32'd1 : (w_b_neg ? (32'd0 - SrcB) : SrcB);
  assign w_q_mag = w_a_mag / w_b_mag;
  assign w_r_mag = w_a_mag % w_b_mag;
  assign w_quo   = (w_a_neg ^ w_b_neg) ? (32'd0 - w_q_mag) : w_q_mag;
  assign w_rem   = w_a_neg ? (32'd0 - w_r_mag) : w_r_mag;

`ifdef MDU_MADD_EN
  logic        w_acc_signed;
  logic        w_acc_sub;
  logic [63:0] w_acc_prod;
  logic [63:0] w_acc_res;

  assign w_acc_signed = (MDUOp == OP_MADD) || (MDUOp == OP_MSUB);
  assign w_acc_sub    = (MDUOp == OP_MSUB) || (MDUOp == OP_MSUBU);
  assign w_acc_prod   = w_acc_signed ? w_prod_s : w_prod_u;
  assign w_acc_res    = w_acc_sub ? ({r_hi, r_lo} - w_acc_prod)
                                  : ({r_hi, r_lo} + w_acc_prod);
`endif

  always_comb begin
    w_result = 64'd0;
    case (MDUOp)
      OP_MULT:  w_result = w_prod_s;
      OP_MULTU: w_result = w_prod_u;
      OP_DIV,
      OP_DIVU:  w_result = {w_rem, w_quo};
`ifdef MDU_MADD_EN
      OP_MADD,
      OP_MADDU,
      OP_MSUB,
      OP_MSUBU: w_result = w_acc_res;
`endif
      default:  w_result = 64'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE: if (w_launch) w_state_nxt = S_RUN;
      S_RUN: begin
        if (r_cnt <= 5'd1) begin
          w_state_nxt = S_IDLE;
          w_done      = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= 5'd0;
      r_hi  <= 32'd0;
      r_lo  <= 32'd0;
      r_phi <= 32'd0;
      r_plo <= 32'd0;
      r_pwr <= 1'b0;
    end else if (w_launch) begin
      r_cnt <= w_op_div ? LP_DIV_CNT : LP_MULT_CNT;
      r_phi <= w_result[63:32];
      r_plo <= w_result[31:0];
      r_pwr <= !w_div_zero;
    end else if (r_state == S_RUN) begin
      r_cnt <= r_cnt - 5'd1;
      if (w_done && r_pwr) begin
        r_hi <= r_phi;
        r_lo <= r_plo;
      end
    end else if (w_idle_start) begin
      if (MDUOp == OP_MTHI) r_hi <= SrcA;
      if (MDUOp == OP_MTLO) r_lo <= SrcA;
    end
  end

  assign Busy = (r_state == S_RUN);
  assign HI   = r_hi;
  assign LO   = r_lo;

endmodule

// File: tb/tb_mdu.sv
// tb_mdu: directed vectors for mdu; a monitor checks HI/LO and Busy length
// against scoreboard queues filled by the stimulus process.
module tb_mdu;

  localparam logic [3:0] OP_NONE  = 4'd0;
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MADDU = 4'd8;
  localparam logic [3:0] OP_MSUB  = 4'd9;

  typedef struct {
    string       nm;
    logic [31:0] hi;
    logic [31:0] lo;
    int          aux;   // busy length for completions, Busy level for snapshots
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] SrcA = '0;
  logic [31:0] SrcB = '0;
  logic [3:0]  MDUOp = OP_NONE;
  logic        Start = 1'b0;
  logic        Busy;
  logic [31:0] HI;
  logic [31:0] LO;

  logic        chk_req = 1'b0;
  exp_t        q_done[$];
  exp_t        q_snap[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          run_len = 0;
  logic        prev_busy = 1'b0;

  always #5 clk = ~clk;

  mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .SrcA(SrcA), .SrcB(SrcB), .MDUOp(MDUOp),
    .Start(Start), .Busy(Busy), .HI(HI), .LO(LO)
  );

  task automatic cmp(input string nm, input string fld, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s.%s: got %h expected %h", nm, fld, act, exp);
    end
  endtask

  // Monitor: completions on Busy falling, snapshots on chk_req.
  always @(negedge clk) begin
    exp_t e;
    if (Busy) run_len++;
    else begin
      if (prev_busy) begin
        if (q_done.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_done: got completion expected none");
        end else begin
          e = q_done.pop_front();
          cmp(e.nm, "HI", HI, e.hi);
          cmp(e.nm, "LO", LO, e.lo);
          cmp(e.nm, "busy_cycles", 32'(run_len), 32'(e.aux));
        end
      end
      run_len = 0;
    end
    if (chk_req) begin
      if (q_snap.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_snap: got request expected none");
      end else begin
        e = q_snap.pop_front();
        cmp(e.nm, "HI", HI, e.hi);
        cmp(e.nm, "LO", LO, e.lo);
        cmp(e.nm, "Busy", {31'd0, Busy}, 32'(e.aux));
      end
    end
    prev_busy = Busy;
  end

  task automatic start_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    Start = 1'b1; MDUOp = op; SrcA = a; SrcB = b;
    @(posedge clk); #1;
    Start = 1'b0; MDUOp = OP_NONE;
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while (Busy && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (Busy) begin
      n_cmp++; n_bad++;
      $display("FAIL %s.timeout: got Busy=1 after %0d cycles expected 0", nm, n);
    end
    @(posedge clk); #1;
  endtask

  task automatic run_op(input string nm, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] hi, input logic [31:0] lo,
                        input int len);
    exp_t e;
    e.nm = nm; e.hi = hi; e.lo = lo; e.aux = len;
    q_done.push_back(e);
    start_op(op, a, b);
    wait_idle(nm);
  endtask

  task automatic snap(input string nm, input logic [31:0] hi, input logic [31:0] lo, input int busy);
    exp_t e;
    e.nm = nm; e.hi = hi; e.lo = lo; e.aux = busy;
    q_snap.push_back(e);
    chk_req = 1'b1;
    @(posedge clk); #1;
    chk_req = 1'b0;
  endtask

  initial begin
    exp_t e;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    snap("reset", 32'h0, 32'h0, 0);

    run_op("mult",      OP_MULT,  32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFE, 5);
    run_op("multu",     OP_MULTU, 32'hFFFFFFFF, 32'd2, 32'h00000001, 32'hFFFFFFFE, 5);
    run_op("div_neg",   OP_DIV,   32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 10);
    run_op("div_negb",  OP_DIV,   32'd7, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 10);
    run_op("divu",      OP_DIVU,  32'd7, 32'd2, 32'h00000001, 32'h00000003, 10);
    run_op("div_ovf",   OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 10);
    run_op("div_min_1", OP_DIV,   32'h80000000, 32'd1, 32'h0, 32'h80000000, 10);

    start_op(OP_MTHI, 32'h12345678, 32'h0);
    snap("mthi", 32'h12345678, 32'h80000000, 0);
    start_op(OP_MTLO, 32'h9ABCDEF0, 32'h0);
    snap("mtlo", 32'h12345678, 32'h9ABCDEF0, 0);

    run_op("div_by0",  OP_DIV,  32'd55, 32'd0, 32'h12345678, 32'h9ABCDEF0, 10);
    run_op("divu_by0", OP_DIVU, 32'd55, 32'd0, 32'h12345678, 32'h9ABCDEF0, 10);

    // MULT aborted by reset; a Start+MTLO during RUN must be ignored.
    e.nm = "abort"; e.hi = 32'h0; e.lo = 32'h0; e.aux = 3;
    q_done.push_back(e);
    start_op(OP_MULT, 32'd5, 32'd6);
    @(posedge clk); #1;
    Start = 1'b1; MDUOp = OP_MTLO; SrcA = 32'hDEADBEEF;
    @(posedge clk); #1;
    Start = 1'b0; MDUOp = OP_NONE; reset = 1'b1;
    snap("mtlo_in_run", 32'h12345678, 32'h9ABCDEF0, 1);
    reset = 1'b0;
    snap("after_abort", 32'h0, 32'h0, 0);
    run_op("mult_3x4", OP_MULT, 32'd3, 32'd4, 32'h0, 32'd12, 5);

    start_op(OP_MTHI, 32'h0, 32'h0);
    start_op(OP_MTLO, 32'hFFFFFFFF, 32'h0);
    snap("pre_acc", 32'h0, 32'hFFFFFFFF, 0);
`ifdef MDU_MADD_EN
    run_op("maddu", OP_MADDU, 32'd1, 32'd1, 32'h1, 32'h0, 5);
    run_op("msub",  OP_MSUB,  32'd1, 32'd2, 32'h0, 32'hFFFFFFFE, 5);
`else
    start_op(OP_MADDU, 32'd1, 32'd1);
    snap("maddu_reserved", 32'h0, 32'hFFFFFFFF, 0);
    start_op(4'd15, 32'hAAAA5555, 32'd3);
    snap("op15_reserved", 32'h0, 32'hFFFFFFFF, 0);
`endif

    repeat (3) @(posedge clk);
    #1;
    if (q_done.size() != 0 || q_snap.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL leftover: got %0d/%0d pending expected 0/0", q_done.size(), q_snap.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mdu.md
Name: mdu

Overview:
- Multi-cycle multiply/divide unit in the EX stage, alongside the ALU.
- Takes the same forwarded SrcA/SrcB operands and owns the architectural HI/LO registers.
- Busy drives the hazard unit, which stalls any later MDU instruction (including MFHI/MFLO) while an operation is in flight.
- HI/LO feed the EX-stage result mux for MFHI/MFLO.

Parameters:
MULT_CYCLES, 5, cycles Busy stays high for MULT/MULTU (and MADD-family when enabled); legal range 1..31
DIV_CYCLES, 10, cycles Busy stays high for DIV/DIVU; legal range 1..31

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
SrcA  input  32  operand rs (forwarded)
SrcB  input  32  operand rt (forwarded)
MDUOp  input  4  operation: 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MADD, 8 MADDU, 9 MSUB, 10 MSUBU; 11-15 reserved
Start  input  1  qualifies MDUOp for one cycle
Busy  output  1  operation in flight
HI  output  32  architectural HI register
LO  output  32  architectural LO register

Behaviour:
- Reset (sync, active-high): HI=0, LO=0, Busy=0, counter=0. Any operation in flight is discarded. Reset has priority over every other input.
- States: IDLE and RUN.
- IDLE:
  - Start with MULT/MULTU/DIV/DIVU (or MADD-family when enabled) at edge T:
    - Capture SrcA/SrcB.
    - Compute the 64-bit result into internal pending registers {PHI,PLO}.
    - Load counter with MULT_CYCLES or DIV_CYCLES; go to RUN. Busy=1 from cycle T+1.
  - Start with MTHI: HI<=SrcA at edge T, single cycle, Busy stays 0. MTLO likewise writes LO.
  - Start with NONE or a reserved code: no effect.
- RUN:
  - Counter decrements each edge.
  - At the edge where counter reaches 0: HI<=PHI, LO<=PLO, Busy<=0, go to IDLE.
  - Net result: Busy is high for exactly N cycles (T+1..T+N); new HI/LO are visible in cycle T+N+1, the same cycle Busy is low.
  - HI/LO keep their old values throughout RUN.
- Start during RUN is ignored entirely, including MTHI/MTLO. The hazard unit guarantees Start is never asserted while Busy=1; the bench checks that it is ignored anyway.
- Arithmetic:
  - MULT: signed 32x32 -> 64; HI=upper 32 bits, LO=lower 32 bits.
  - MULTU: as MULT, unsigned.
  - DIV: signed; LO=quotient truncated toward zero, HI=remainder with the sign of the dividend (SrcA).
  - DIVU: as DIV, unsigned.
  - DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
  - Divide by zero (SrcB=0, DIV or DIVU): still runs the full DIV_CYCLES with Busy high; HI/LO left unchanged at completion.
- HI/LO are plain registered outputs with no combinational path from inputs.

Optional Feature:
- Macro: MDU_MADD_EN.
- Defined:
  - MADD: {HI,LO} += signed SrcA*SrcB.
  - MADDU: {HI,LO} += unsigned SrcA*SrcB.
  - MSUB: {HI,LO} -= signed SrcA*SrcB.
  - MSUBU: {HI,LO} -= unsigned SrcA*SrcB.
  - All arithmetic is modulo 2^64, uses {HI,LO} as sampled at the Start edge, and has MULT_CYCLES latency.
- Not defined: codes 7-10 are treated as reserved (no effect, Busy stays 0). The accumulate logic is absent from the netlist.

Test Plan:
- Reset then MULT SrcA=0xFFFFFFFF (-1), SrcB=2 -> Busy high exactly 5 cycles; next cycle HI=0xFFFFFFFF, LO=0xFFFFFFFE. MULTU with the same operands -> HI=0x00000001, LO=0xFFFFFFFE.
- DIV SrcA=-7 (0xFFFFFFF9), SrcB=2 -> after 10 Busy cycles LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1). DIVU 7/2 -> LO=3, HI=1.
- MTHI 0x12345678, then MTLO 0x9ABCDEF0 -> Busy never asserts; values visible the cycle after each Start. Then DIV x/0 -> Busy high 10 cycles, HI/LO still 0x12345678/0x9ABCDEF0.
- MULT started; assert Start+MTLO 0xDEADBEEF in Busy cycle 2; assert reset in cycle 3 -> MTLO ignored; next cycle HI=LO=0, Busy=0; a fresh MULT 3*4 then yields LO=12, HI=0.
- Boundary: DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0. Also DIV 0x80000000 / 1 -> LO=0x80000000, HI=0.
- With MDU_MADD_EN: MTHI 0, MTLO 0xFFFFFFFF, then MADDU 1*1 -> HI=1, LO=0; then MSUB 1*2 -> HI=0, LO=0xFFFFFFFE. Without the macro, the MADDU Start leaves Busy=0 and HI/LO unchanged.
